// File: rtl/adxl355_sched.sv
// adxl355_sched: read-cycle sequencer for the ADXL355 SPI reader/buffer.
// Generates the reader clk_en strobe and triggers reads from DRDY or an
// internal timer. It also arbitrates ESP32 direct SPI access between
// read cycles.
// Optional build macro ADXL355_SCHED_TEMP_EN: after every TEMP_EVERY-1 XYZ
// cycles, one temperature cycle (cmd 8'h0D, len 3) is inserted.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | reader idle; direct request has priority over a pending trigger
// ISSUE    | sync pulse out, cmd/len/tag valid, tick counter loaded
// BUSY     | reader cycle in flight; tick counter counts down on clk_en
// HANDOVER | direct requested from reader, waiting for direct_en
// DIRECT   | ESP32 owns the SPI bus (direct_gnt=1)
// RELEASE  | direct dropped, waiting for the reader to return the bus
module adxl355_sched #(
    parameter int          CLK_EN_DIV = 4,
    parameter int          USE_DRDY   = 1,
    parameter int          PERIOD     = 80000,
    parameter int          GUARD      = 4,
    parameter logic [17:0] TAG_SEL    = 18'h00124,
    parameter int          TEMP_EVERY = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        drdy,
    input  logic        direct_req,
    input  logic        direct_en,
    output logic        clk_en,
    output logic        sync,
    output logic [7:0]  cmd,
    output logic [3:0]  len,
    output logic [17:0] tag_byte_select,
    output logic        direct,
    output logic        direct_gnt,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);

    localparam int DIV_W = (CLK_EN_DIV > 1) ? $clog2(CLK_EN_DIV) : 1;
    localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_EN_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);

    // The 4-bit XYZ counter limits TEMP_EVERY to 16; the reader needs 4 clk per tick.
    if (CLK_EN_DIV < 4 || TEMP_EVERY < 2 || TEMP_EVERY > 16) begin : g_param_check
        $error("adxl355_sched: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_HANDOVER,
        S_DIRECT,
        S_RELEASE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [PER_W-1:0] tmr;
    logic             drdy_meta, drdy_sync, drdy_prev;
    logic             drdy_rise, tmr_wrap, trig;
    logic             pending;
    logic [11:0]      tick;
    logic [11:0]      cycle_ticks;
`ifdef ADXL355_SCHED_TEMP_EN
    logic [3:0]       xyz_cnt;
`endif

    assign clk_en      = (div_cnt == DIV_LAST);
    assign drdy_rise   = drdy_sync & ~drdy_prev;
    assign tmr_wrap    = (tmr == PER_LAST);
    assign trig        = (USE_DRDY != 0) ? drdy_rise : tmr_wrap;
    // Nominal transfer (len bytes * 16 ticks + 6) plus guard for the reader's channel drain.
    assign cycle_ticks = {4'd0, len, 4'd0} + 12'd6 + 12'(GUARD);

    // Free-running strobe divider.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else div_cnt <= div_cnt + 1'b1;
    end

    // DRDY two-flop synchronizer plus a delay stage for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) {drdy_prev, drdy_sync, drdy_meta} <= 3'b000;
        else {drdy_prev, drdy_sync, drdy_meta} <= {drdy_sync, drdy_meta, drdy};
    end

    // Internal trigger period timer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tmr <= '0;
        else if (tmr_wrap) tmr <= '0;
        else tmr <= tmr + 1'b1;
    end

    // Pending flag and overrun count. A trigger in the ISSUE clock keeps the new request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else if (trig) begin
            pending <= 1'b1;
            if (pending && state != S_ISSUE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end else if (state == S_ISSUE) begin
            pending <= 1'b0;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= S_IDLE;
            sync            <= 1'b0;
            cmd             <= 8'h11;
            len             <= 4'd10;
            tag_byte_select <= TAG_SEL;
            direct          <= 1'b0;
            direct_gnt      <= 1'b0;
            busy            <= 1'b0;
            tick            <= 12'd0;
`ifdef ADXL355_SCHED_TEMP_EN
            xyz_cnt         <= 4'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (direct_req) begin
                        direct <= 1'b1;
                        state  <= S_HANDOVER;
                    end else if (pending) begin
                        sync  <= 1'b1;
                        busy  <= 1'b1;
                        state <= S_ISSUE;
`ifdef ADXL355_SCHED_TEMP_EN
                        if (xyz_cnt == 4'(TEMP_EVERY - 1)) begin
                            cmd             <= 8'h0D;
                            len             <= 4'd3;
                            tag_byte_select <= 18'd0;
                            xyz_cnt         <= 4'd0;
                        end else begin
                            cmd             <= 8'h11;
                            len             <= 4'd10;
                            tag_byte_select <= TAG_SEL;
                            xyz_cnt         <= xyz_cnt + 4'd1;
                        end
`else
                        cmd             <= 8'h11;
                        len             <= 4'd10;
                        tag_byte_select <= TAG_SEL;
`endif
                    end
                end
                S_ISSUE: begin
                    sync  <= 1'b0;
                    // A strobe in the ISSUE clock already counts toward the window.
                    tick  <= clk_en ? cycle_ticks - 12'd1 : cycle_ticks;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (clk_en) begin
                        if (tick <= 12'd1) begin
                            tick  <= 12'd0;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            tick <= tick - 12'd1;
                        end
                    end
                end
                S_HANDOVER: begin
                    if (direct_en) begin
                        direct_gnt <= 1'b1;
                        state      <= S_DIRECT;
                    end
                end
                S_DIRECT: begin
                    if (!direct_req) begin
                        direct <= 1'b0;
                        state  <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!direct_en) begin
                        direct_gnt <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adxl355_sched.sv
// Directed bench for adxl355_sched. Inputs change on the falling edge and
// outputs are sampled there too. With ADXL355_SCHED_TEMP_EN defined, the bench
// runs the timer/temperature sequence instead of the DRDY/direct sequence.
module tb_adxl355_sched;

    logic        clk = 1'b0;
    logic        rstn, drdy, direct_req, direct_en;
    logic        clk_en, sync, direct, direct_gnt, busy;
    logic [7:0]  cmd, overrun_cnt;
    logic [3:0]  len;
    logic [17:0] tag_byte_select;

    int checks = 0;
    int errors = 0;
    int lat, ticks, nsync, cnt, last, gap_bad;
    logic sync_seen;

    always #5 clk = ~clk;

`ifdef ADXL355_SCHED_TEMP_EN
    adxl355_sched #(.USE_DRDY(0), .PERIOD(1000), .TEMP_EVERY(4)) dut (
`else
    adxl355_sched dut (
`endif
        .clk(clk), .rstn(rstn), .drdy(drdy), .direct_req(direct_req),
        .direct_en(direct_en), .clk_en(clk_en), .sync(sync), .cmd(cmd),
        .len(len), .tag_byte_select(tag_byte_select), .direct(direct),
        .direct_gnt(direct_gnt), .busy(busy), .overrun_cnt(overrun_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sync === 1'b1) sync_seen = 1'b1;
        end
    endtask

    task automatic pulse_drdy();
        drdy = 1'b1;
        tick_n(3);
        drdy = 1'b0;
        tick_n(3);
    endtask

    // Returns the number of falling edges until sync is seen, or -1.
    task automatic wait_sync(input int budget, output int l);
        l = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (sync === 1'b1) begin
                l = i;
                break;
            end
        end
    endtask

    // Counts clk_en and sync samples while busy is high; ticks=-1 on timeout.
    task automatic count_busy(input int budget, output int t, output int s);
        bit done = 1'b0;
        t = 0;
        s = 0;
        for (int i = 0; i < budget; i++) begin
            if (busy !== 1'b1) begin
                done = 1'b1;
                break;
            end
            if (clk_en === 1'b1) t++;
            if (sync === 1'b1) s++;
            @(negedge clk);
        end
        if (!done) t = -1;
    endtask

    initial begin
        rstn = 1'b0; drdy = 1'b0; direct_req = 1'b0; direct_en = 1'b0;
        tick_n(3);
        chk("rst_clk_en", clk_en, 0);
        chk("rst_sync", sync, 0);
        chk("rst_cmd", cmd, 8'h11);
        chk("rst_len", len, 4'd10);
        chk("rst_tag", tag_byte_select, 18'h00124);
        chk("rst_direct", direct, 0);
        chk("rst_gnt", direct_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun_cnt, 0);
        rstn = 1'b1;

`ifdef ADXL355_SCHED_TEMP_EN
        begin
            logic [7:0] exp_cmd [5] = '{8'h11, 8'h11, 8'h11, 8'h0D, 8'h11};
            for (int i = 0; i < 5; i++) begin
                wait_sync(1200, lat);
                chk("temp_sync_seen", (lat > 0), 1);
                chk("temp_cmd", cmd, exp_cmd[i]);
                chk("temp_len", len, (exp_cmd[i] == 8'h0D) ? 4'd3 : 4'd10);
                chk("temp_tag", tag_byte_select, (exp_cmd[i] == 8'h0D) ? 18'd0 : 18'h00124);
                count_busy(1000, ticks, nsync);
                chk("temp_busy_ticks", ticks, (exp_cmd[i] == 8'h0D) ? 58 : 170);
            end
        end
`else
        // Free-running strobe: one pulse every 4 clocks, no sync while idle.
        tick_n(1);
        cnt = 0; last = -1; gap_bad = 0; sync_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (sync === 1'b1) sync_seen = 1'b1;
            if (clk_en === 1'b1) begin
                if (last >= 0 && i - last != 4) gap_bad = 1;
                last = i;
                cnt++;
            end
        end
        chk("clk_en_count", cnt, 4);
        chk("clk_en_gap", gap_bad, 0);
        chk("idle_no_sync", sync_seen, 0);

        // Single DRDY edge -> one XYZ cycle of 170 ticks.
        drdy = 1'b1;
        wait_sync(10, lat);
        chk("sync_latency_3_4", (lat == 3 || lat == 4), 1);
        chk("xyz_cmd", cmd, 8'h11);
        chk("xyz_len", len, 4'd10);
        chk("xyz_tag", tag_byte_select, 18'h00124);
        chk("xyz_busy", busy, 1);
        drdy = 1'b0;
        count_busy(2000, ticks, nsync);
        chk("xyz_busy_ticks", ticks, 170);
        chk("sync_one_clk", nsync, 1);

        // Direct request during BUSY waits for the cycle to end.
        tick_n(4);
        pulse_drdy();
        direct_req = 1'b1;
        tick_n(20);
        chk("direct_held_busy", direct, 0);
        count_busy(2000, ticks, nsync);
        chk("direct_busy_fall", (ticks > 0), 1);
        sync_seen = 1'b0;
        tick_watch(1);
        chk("direct_after_busy", direct, 1);
        tick_watch(2);
        direct_en = 1'b1;
        tick_watch(1);
        chk("direct_gnt_on", direct_gnt, 1);
        drdy = 1'b1;
        tick_watch(3);
        drdy = 1'b0;
        tick_watch(10);
        chk("direct_no_sync", sync_seen, 0);
        direct_req = 1'b0;
        tick_watch(1);
        chk("direct_dropped", direct, 0);
        chk("gnt_held_release", direct_gnt, 1);
        direct_en = 1'b0;
        tick_watch(1);
        chk("gnt_dropped", direct_gnt, 0);
        chk("release_no_sync", sync_seen, 0);
        wait_sync(4, lat);
        chk("pending_after_direct", (lat > 0), 1);
        count_busy(2000, ticks, nsync);
        chk("post_direct_ticks", ticks, 170);
        chk("ovr_after_direct", overrun_cnt, 0);

        // Two more edges inside one BUSY window: one overrun, one pending issue.
        tick_n(4);
        drdy = 1'b1;
        wait_sync(10, lat);
        drdy = 1'b0;
        chk("ovr_first_sync", (lat > 0), 1);
        tick_n(3);
        pulse_drdy();
        pulse_drdy();
        chk("ovr_one", overrun_cnt, 1);
        count_busy(2000, ticks, nsync);
        wait_sync(4, lat);
        chk("ovr_pending_issue", (lat > 0), 1);

        // Many edges: overrun saturates.
        for (int i = 0; i < 300; i++) begin
            drdy = 1'b1;
            tick_n(2);
            drdy = 1'b0;
            tick_n(2);
        end
        chk("ovr_saturate", overrun_cnt, 8'd255);

        // Async reset mid-BUSY.
        lat = -1;
        for (int i = 1; i <= 2000; i++) begin
            if (busy === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        chk("busy_before_reset", (lat > 0), 1);
        tick_n(5);
        rstn = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_sync", sync, 0);
        chk("rstmid_direct", direct, 0);
        chk("rstmid_ovr", overrun_cnt, 0);
        tick_n(3);
        rstn = 1'b1;
        tick_n(3);
        drdy = 1'b1;
        wait_sync(10, lat);
        chk("post_rst_latency", (lat == 3 || lat == 4), 1);
        chk("post_rst_cmd", cmd, 8'h11);
        drdy = 1'b0;
        count_busy(2000, ticks, nsync);
        chk("post_rst_ticks", ticks, 170);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adxl355_sched.md
Name: adxl355_sched

Overview:
- Sequencer that drives the ADXL355 SPI reader/buffer block.
- Generates the reader's clk_en strobe and schedules each read cycle from either the sensor DRDY pin or an internal period timer.
- Selects cmd/len/tag mask per cycle and issues the one-cycle sync.
- Arbitrates ESP32 requests for direct SPI access: hands over only between cycles and resumes afterwards.

Parameters:
CLK_EN_DIV, 4, clk cycles per clk_en pulse (min 4; 80 MHz clk -> 20 MHz strobe)
USE_DRDY, 1, 1: trigger on synchronized drdy rising edge; 0: internal timer
PERIOD, 80000, internal trigger period in clk cycles (USE_DRDY=0)
GUARD, 4, extra clk_en ticks after nominal end before reader counts as idle
TAG_SEL, 18'h00124, tag_byte_select for XYZ cycles (tags bytes 2,5,8)
TEMP_EVERY, 16, XYZ cycles between temperature reads (optional feature only)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
drdy  in  1  ADXL355 DRDY pin, asynchronous
direct_req  in  1  ESP32 request for direct SPI access
direct_en  in  1  grant returned by reader
clk_en  out  1  one-clk strobe to reader
sync  out  1  one-clk start pulse to reader
cmd  out  8  SPI command byte to reader
len  out  4  transfer length incl. cmd byte
tag_byte_select  out  18  tag mask to reader
direct  out  1  direct request forwarded to reader
direct_gnt  out  1  grant to ESP32 (= direct_en registered)
busy  out  1  reader cycle in flight
overrun_cnt  out  8  saturating count of dropped triggers

Behaviour:
- Reset values: clk_en=0, sync=0, cmd=8'h11, len=4'd10, tag_byte_select=TAG_SEL, direct=0, direct_gnt=0, busy=0, overrun_cnt=0. All state, counters and the pending flag are cleared.
- clk_en: a free-running mod-CLK_EN_DIV counter. clk_en=1 for exactly one clk when the counter = CLK_EN_DIV-1.
- drdy path: 2-FF synchronizer, then rising-edge detect. Trigger latency is 3 clk from the drdy edge.
- Timer path: mod-PERIOD counter emits a trigger when it wraps.
- Pending flag:
  - A trigger sets pending.
  - A trigger while pending is already 1 increments overrun_cnt, saturating at 255; pending stays 1.
  - A trigger in the same clk as the pending clear (ISSUE) re-sets pending.
- State machine:
  - IDLE: if direct_req=1, go to HANDOVER. Else if pending=1, go to ISSUE.
  - ISSUE, 1 clk:
    - Drive cmd/len/tag_byte_select for the chosen cycle and assert sync for this single clk.
    - Clear pending and load the tick counter with len*16+6+GUARD.
    - busy=1, go to BUSY.
  - BUSY: decrement the tick counter on each clk_en. At 0: busy=0, go to IDLE.
  - HANDOVER: direct=1. When direct_en=1, go to DIRECT.
  - DIRECT: direct_gnt=1. When direct_req=0, drop direct and go to RELEASE.
  - RELEASE: wait for direct_en=0, then drop direct_gnt and go to IDLE.
- Triggers during HANDOVER/DIRECT/RELEASE still set pending and count overruns. The pending cycle is issued on return to IDLE.
- Priority in IDLE: direct_req wins over pending.
- cmd/len/tag_byte_select stay stable from ISSUE until the next ISSUE.
- The reader ignores sync unless idle. The BUSY window guarantees that condition; GUARD must cover the reader's second-channel drain (len-2 clk).
- direct_req dropped during HANDOVER before the grant arrives: still go to DIRECT, then release normally. No abort path.
- Reset mid-cycle: outputs return to reset values immediately (async). The reader finishes or is recovered by its own logic.
- XYZ cycle: cmd=8'h11, len=10, tag_byte_select=TAG_SEL.

Optional Feature:
- Macro: ADXL355_SCHED_TEMP_EN.
- Defined:
  - A 4-bit XYZ cycle counter increments at each XYZ ISSUE.
  - When it reaches TEMP_EVERY-1, the next ISSUE is a temperature cycle: cmd=8'h0D, len=3, tag_byte_select=0. The counter then clears.
  - The BUSY length follows the issued len.
- Undefined: every cycle is XYZ; the counter logic is absent.

Test Plan:
- Reset then run free: clk_en high 1 clk every 4 clk; sync=0; cmd=8'h11, len=10.
- USE_DRDY=1, drdy rises once: sync pulse 3-4 clk later with cmd=8'h11, len=10, tag_byte_select=18'h00124. busy stays high for exactly 10*16+6+4=170 clk_en ticks.
- Two drdy edges inside one BUSY window plus a third: one pending cycle is issued right after busy falls, and overrun_cnt=1. Repeat 300 times -> overrun_cnt saturates at 255.
- direct_req=1 during BUSY: direct stays 0 until busy falls, then direct=1. Model direct_en high 2 clk later -> direct_gnt=1 and no sync is issued. Drop direct_req -> direct=0. direct_en=0 -> direct_gnt=0, then the pending trigger issues sync.
- ADXL355_SCHED_TEMP_EN, TEMP_EVERY=4, USE_DRDY=0, PERIOD=1000: cmd sequence 11,11,11,0D,11,... The 0D cycle has len=3 and busy=3*16+6+4=58 ticks.
- rstn asserted mid-BUSY: busy, sync and direct go to 0 in the same cycle; after release, the first trigger issues sync normally.
